// File: rtl/vend_controller.sv
// Coin-operated vending transaction controller: accumulates nickel/dime/quarter
// credit against PRICE, handshakes with the dispenser, then pays change or refunds.
module vend_controller #(
    parameter int PRICE   = 100,
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        nickel,
    input  logic        dime,
    input  logic        quarter,
    input  logic        cancel,
    input  logic        dispense_ack,
    output logic        dispense_req,
    output logic        change_nickel,
    output logic        change_dime,
    output logic        change_quarter,
    output logic        coin_reject,
    output logic [7:0]  credit,
    output logic [15:0] sale_count,
    output logic        busy
);

    localparam int              TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   TMR_MAX  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   TMR_ONE  = TW'(1);
    localparam logic [TW-1:0]   TMR_ZERO = TW'(0);
    localparam logic [7:0]      PRICE8   = 8'(PRICE);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_REFUND   = 3'd4
    } state_t;

    state_t          state_r, state_next_s;
    logic [7:0]      credit_r, credit_next_s;
    logic [15:0]     sale_count_r;
    logic [TW-1:0]   tmr_r, tmr_next_s;
    logic [7:0]      coin_sum_s, credit_sum_s;
    logic            sale_inc_s, reject_s;
    logic            chg_n_s, chg_d_s, chg_q_s;

    assign coin_sum_s   = (nickel  ? 8'd5  : 8'd0)
                        + (dime    ? 8'd10 : 8'd0)
                        + (quarter ? 8'd25 : 8'd0);
    assign credit_sum_s = credit_r + coin_sum_s;
    assign credit       = credit_r;
    assign sale_count   = sale_count_r;

    // Next-state, credit, idle timer and payout coin selection
    always_comb begin
        state_next_s  = state_r;
        credit_next_s = credit_r;
        tmr_next_s    = tmr_r;
        sale_inc_s    = 1'b0;
        reject_s      = 1'b0;
        chg_n_s       = 1'b0;
        chg_d_s       = 1'b0;
        chg_q_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                credit_next_s = 8'd0;
                tmr_next_s    = TMR_ZERO;
                if (coin_sum_s != 8'd0) begin
                    credit_next_s = coin_sum_s;
                    state_next_s  = ST_COLLECT;
                end else begin
                    state_next_s  = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                credit_next_s = credit_sum_s;
                if (cancel) begin
                    state_next_s = ST_REFUND;
                end else if (credit_sum_s >= PRICE8) begin
                    state_next_s = ST_DISPENSE;
                end else if (coin_sum_s != 8'd0) begin
                    tmr_next_s   = TMR_ZERO;
                end else if (tmr_r == TMR_MAX) begin
                    state_next_s = ST_REFUND;
                end else begin
                    tmr_next_s   = tmr_r + TMR_ONE;
                end
            end
            ST_DISPENSE: begin
                reject_s = (coin_sum_s != 8'd0);
                if (dispense_ack) begin
                    credit_next_s = credit_r - PRICE8;
                    sale_inc_s    = 1'b1;
                    state_next_s  = (credit_r == PRICE8) ? ST_IDLE : ST_CHANGE;
                end else begin
                    state_next_s  = ST_DISPENSE;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                // Stay until credit is exhausted so busy falls one cycle after the last pulse
                reject_s = (coin_sum_s != 8'd0);
                if (credit_r == 8'd0) begin
                    state_next_s  = ST_IDLE;
                end else if (credit_r >= 8'd25) begin
                    chg_q_s       = 1'b1;
                    credit_next_s = credit_r - 8'd25;
                end else if (credit_r >= 8'd10) begin
                    chg_d_s       = 1'b1;
                    credit_next_s = credit_r - 8'd10;
                end else begin
                    chg_n_s       = 1'b1;
                    credit_next_s = credit_r - 8'd5;
                end
            end
            default: begin
                state_next_s  = ST_IDLE;
                credit_next_s = 8'd0;
                tmr_next_s    = TMR_ZERO;
            end
        endcase
    end

    // State, credit and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            credit_r       <= 8'd0;
            tmr_r          <= TMR_ZERO;
            sale_count_r   <= 16'd0;
            dispense_req   <= 1'b0;
            change_nickel  <= 1'b0;
            change_dime    <= 1'b0;
            change_quarter <= 1'b0;
            coin_reject    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            credit_r       <= credit_next_s;
            tmr_r          <= tmr_next_s;
            if (sale_inc_s) begin
                sale_count_r <= sale_count_r + 16'd1;
            end
            dispense_req   <= (state_next_s == ST_DISPENSE);
            change_nickel  <= chg_n_s;
            change_dime    <= chg_d_s;
            change_quarter <= chg_q_s;
            coin_reject    <= reject_s;
            busy           <= (state_next_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus random coin
// traffic, compared every cycle against a transaction-level reference model.
module tb_vend_controller;

    localparam int PRICE   = 100;
    localparam int TIMEOUT = 12;

    logic        clk = 1'b0;
    logic        reset_n, nickel, dime, quarter, cancel, dispense_ack;
    logic        dispense_req, change_nickel, change_dime, change_quarter;
    logic        coin_reject, busy;
    logic [7:0]  credit;
    logic [15:0] sale_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: phase 0 waiting, 1 taking coins, 2 item pending, 3 paying out
    int m_phase, m_credit, m_sales, m_quiet;
    int pay_q[$];
    bit m_rej, m_cn, m_cd, m_cq;

    vend_controller #(.PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .nickel(nickel), .dime(dime), .quarter(quarter),
        .cancel(cancel), .dispense_ack(dispense_ack),
        .dispense_req(dispense_req),
        .change_nickel(change_nickel), .change_dime(change_dime),
        .change_quarter(change_quarter),
        .coin_reject(coin_reject), .credit(credit),
        .sale_count(sale_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = 0; m_credit = 0; m_sales = 0; m_quiet = 0;
        pay_q.delete();
        m_rej = 1'b0; m_cn = 1'b0; m_cd = 1'b0; m_cq = 1'b0;
    endtask

    // Greedy change list worked out in one go from the amount owed
    task automatic start_payout();
        int rem;
        m_phase = 3;
        pay_q.delete();
        rem = m_credit;
        repeat (rem / 25) pay_q.push_back(25);
        rem = rem % 25;
        repeat (rem / 10) pay_q.push_back(10);
        rem = rem % 10;
        repeat (rem / 5) pay_q.push_back(5);
    endtask

    task automatic model_step(input bit n, input bit d, input bit q, input bit c, input bit a);
        int s;
        int coin;
        s = 5 * n + 10 * d + 25 * q;
        m_rej = 1'b0; m_cn = 1'b0; m_cd = 1'b0; m_cq = 1'b0;
        case (m_phase)
            0: if (s > 0) begin m_credit = s; m_phase = 1; m_quiet = 0; end
            1: begin
                if (c) begin
                    m_credit = m_credit + s;
                    start_payout();
                end else if (m_credit + s >= PRICE) begin
                    m_credit = m_credit + s;
                    m_phase = 2;
                end else if (s > 0) begin
                    m_credit = m_credit + s;
                    m_quiet = 0;
                end else if (m_quiet == TIMEOUT - 1) begin
                    start_payout();
                end else begin
                    m_quiet++;
                end
            end
            2: begin
                m_rej = (s > 0);
                if (a) begin
                    m_credit = m_credit - PRICE;
                    m_sales = (m_sales + 1) % 65536;
                    if (m_credit > 0) start_payout();
                    else m_phase = 0;
                end
            end
            3: begin
                m_rej = (s > 0);
                if (pay_q.size() > 0) begin
                    coin = pay_q.pop_front();
                    m_credit = m_credit - coin;
                    m_cq = (coin == 25);
                    m_cd = (coin == 10);
                    m_cn = (coin == 5);
                end else begin
                    m_phase = 0;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        vectors++;
        chk("credit",         {8'd0, credit},           16'(m_credit));
        chk("sale_count",     sale_count,               16'(m_sales));
        chk("dispense_req",   {15'd0, dispense_req},    {15'd0, m_phase == 2});
        chk("busy",           {15'd0, busy},            {15'd0, m_phase != 0});
        chk("coin_reject",    {15'd0, coin_reject},     {15'd0, m_rej});
        chk("change_quarter", {15'd0, change_quarter},  {15'd0, m_cq});
        chk("change_dime",    {15'd0, change_dime},     {15'd0, m_cd});
        chk("change_nickel",  {15'd0, change_nickel},   {15'd0, m_cn});
    endtask

    task automatic cycle(input bit n, input bit d, input bit q, input bit c, input bit a);
        nickel = n; dime = d; quarter = q; cancel = c; dispense_ack = a;
        model_step(n, d, q, c, a);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int cnt);
        repeat (cnt) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0; dispense_ack = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;

        // Exact price with four quarters, item pending one cycle, then ack
        repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // 95 cents, then all three coins at once -> 135, change 25 + 10
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4);

        // 40 cents then cancel -> quarter, dime, nickel refund
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);

        // Single dime left to time out
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(TIMEOUT + 4);

        // Coin while the item is pending is rejected
        repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Sales counter wrap from 0xFFFF
        force dut.sale_count_r = 16'hFFFF;
        #1;
        release dut.sale_count_r;
        m_sales = 65535;
        repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Asynchronous reset in the middle of a refund
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        reset_n = 1'b1;
        idle(3);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
                  ($urandom % 40) == 0, ($urandom % 3) == 0);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
